traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_light_pkg.sv | 26 ++
 rtl/tl_phase_timer.sv | 44 ++++
 rtl/traffic_light_ctrl.sv | 166 ++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared types and defaults for the traffic light controller.
//   tl_state_e   : controller state encoding
//   DEF_*        : default phase durations and datapath width
//   fits_width() : true when a value is representable in the given bit width
package traffic_light_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRed,
        StYellow,
        StGreen,
        StFlash
    } tl_state_e;

    localparam int unsigned DEF_CNT_W      = 8;
    localparam int unsigned DEF_RED_T      = 10;
    localparam int unsigned DEF_YELLOW_T   = 5;
    localparam int unsigned DEF_GREEN_T    = 60;
    localparam int unsigned DEF_PASS_T     = 10;
    localparam int unsigned DEF_FLASH_HALF = 4;

    function automatic bit fits_width(input int unsigned value, input int unsigned width);
        return (width >= 32) || ((value >> width) == 0);
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable down-counter that times one light phase.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val at the next edge (highest priority after rst)
//   load_val  : phase duration to load
//   clear     : force count to 0 at the next edge
//   count     : registered remaining cycles; holds at 0, never wraps
//   done      : high while count == 1, i.e. the last cycle of a phase
module tl_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (clear) begin
            count_d = '0;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q == CNT_W'(1));

endmodule

// File: rtl/traffic_light_ctrl.sv
// Traffic light controller: RED -> YELLOW -> GREEN cycle with pedestrian
// shortening of green and a flashing-yellow night/fault mode.
//   clk, rst            : clock, synchronous active-high reset
//   pass_request        : pedestrian request, sampled every cycle
//   flash_mode          : forces flashing yellow while high
//   clock               : remaining cycles of the current phase (0 in IDLE/FLASH)
//   red, yellow, green  : registered lamp drives
//   req_ack             : one-cycle pulse when a request shortens green
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned RED_T      = DEF_RED_T,
    parameter int unsigned YELLOW_T   = DEF_YELLOW_T,
    parameter int unsigned GREEN_T    = DEF_GREEN_T,
    parameter int unsigned PASS_T     = DEF_PASS_T,
    parameter int unsigned FLASH_HALF = DEF_FLASH_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pass_request,
    input  logic             flash_mode,
    output logic [CNT_W-1:0] clock,
    output logic             red,
    output logic             yellow,
    output logic             green,
    output logic             req_ack
);

    if (RED_T < 2 || YELLOW_T < 2 || GREEN_T < 2 || PASS_T < 2 || FLASH_HALF < 2) begin : g_bad_min
        $error("traffic_light_ctrl: every duration must be at least 2");
    end
    if (PASS_T >= GREEN_T) begin : g_bad_pass
        $error("traffic_light_ctrl: PASS_T must be less than GREEN_T");
    end
    if (!fits_width(RED_T, CNT_W) || !fits_width(YELLOW_T, CNT_W) ||
        !fits_width(GREEN_T, CNT_W) || !fits_width(PASS_T, CNT_W) ||
        !fits_width(FLASH_HALF, CNT_W)) begin : g_bad_width
        $error("traffic_light_ctrl: a duration does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] RED_V      = CNT_W'(RED_T);
    localparam logic [CNT_W-1:0] YELLOW_V   = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] GREEN_V    = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] PASS_V     = CNT_W'(PASS_T);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

    tl_state_e        state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic             red_q, yellow_q, green_q, ack_q;
    logic             flash_yel_d, ack_d;

    logic             tmr_load, tmr_clear, phase_done;
    logic [CNT_W-1:0] tmr_val, count;

    tl_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .clear    (tmr_clear),
        .count    (count),
        .done     (phase_done)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        flash_cnt_d = '0;
        flash_yel_d = 1'b0;
        ack_d       = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_clear   = 1'b0;

        if (flash_mode) begin
            state_d   = StFlash;
            pending_d = 1'b0;
            tmr_clear = 1'b1;
            // Entry starts a fresh high half-period; afterwards toggle on each wrap.
            if (state_q != StFlash) begin
                flash_yel_d = 1'b1;
            end else if (flash_cnt_q == FLASH_LAST) begin
                flash_yel_d = ~yellow_q;
            end else begin
                flash_cnt_d = flash_cnt_q + CNT_W'(1);
                flash_yel_d = yellow_q;
            end
        end else begin
            unique case (state_q)
                StIdle, StFlash: begin
                    state_d  = StRed;
                    tmr_load = 1'b1;
                    tmr_val  = RED_V;
                end
                StRed: begin
                    if (pass_request) pending_d = 1'b1;
                    if (phase_done) begin
                        state_d  = StYellow;
                        tmr_load = 1'b1;
                        tmr_val  = YELLOW_V;
                    end
                end
                StYellow: begin
                    if (pass_request) pending_d = 1'b1;
                    if (phase_done) begin
                        state_d  = StGreen;
                        tmr_load = 1'b1;
                        // A request on the last yellow cycle still counts for this green.
                        if (pending_q || pass_request) begin
                            tmr_val   = PASS_V;
                            ack_d     = 1'b1;
                            pending_d = 1'b0;
                        end else begin
                            tmr_val = GREEN_V;
                        end
                    end
                end
                StGreen: begin
                    if (phase_done) begin
                        state_d  = StRed;
                        tmr_load = 1'b1;
                        tmr_val  = RED_V;
                    end else if (pass_request && (count > PASS_V)) begin
                        tmr_load = 1'b1;
                        tmr_val  = PASS_V;
                        ack_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pending_q   <= 1'b0;
            flash_cnt_q <= '0;
            red_q       <= 1'b0;
            yellow_q    <= 1'b0;
            green_q     <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            flash_cnt_q <= flash_cnt_d;
            red_q       <= (state_d == StRed);
            yellow_q    <= (state_d == StYellow) || flash_yel_d;
            green_q     <= (state_d == StGreen);
            ack_q       <= ack_d;
        end
    end

    assign clock   = count;
    assign red     = red_q;
    assign yellow  = yellow_q;
    assign green   = green_q;
    assign req_ack = ack_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl with default parameters.
// Outputs are sampled 1 time unit after each rising edge and compared against
// a phase/remaining-time reference model and directed constant expectations.
module tb_traffic_light_ctrl;

    localparam int CNT_W      = 8;
    localparam int RED_T      = 10;
    localparam int YELLOW_T   = 5;
    localparam int GREEN_T    = 60;
    localparam int PASS_T     = 10;
    localparam int FLASH_HALF = 4;

    localparam int P_IDLE   = 0;
    localparam int P_RED    = 1;
    localparam int P_YELLOW = 2;
    localparam int P_GREEN  = 3;
    localparam int P_FLASH  = 4;

    logic             clk;
    logic             rst;
    logic             pass_request;
    logic             flash_mode;
    logic [CNT_W-1:0] clock;
    logic             red, yellow, green, req_ack;
    logic [CNT_W+3:0] dut_vec;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: current phase, cycles left, pending request,
    // cycles spent in flash mode, and whether this cycle carries an ack.
    int m_phase = P_IDLE;
    int m_rem   = 0;
    bit m_pend  = 1'b0;
    int m_ft    = 0;
    bit m_ack   = 1'b0;

    traffic_light_ctrl #(
        .CNT_W      (CNT_W),
        .RED_T      (RED_T),
        .YELLOW_T   (YELLOW_T),
        .GREEN_T    (GREEN_T),
        .PASS_T     (PASS_T),
        .FLASH_HALF (FLASH_HALF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pass_request (pass_request),
        .flash_mode   (flash_mode),
        .clock        (clock),
        .red          (red),
        .yellow       (yellow),
        .green        (green),
        .req_ack      (req_ack)
    );

    assign dut_vec = {clock, red, yellow, green, req_ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic model_step(input logic pr, input logic fm, input logic r);
        m_ack = 1'b0;
        if (r) begin
            m_phase = P_IDLE;
            m_rem   = 0;
            m_pend  = 1'b0;
            m_ft    = 0;
        end else if (fm) begin
            m_ft    = (m_phase == P_FLASH) ? m_ft + 1 : 0;
            m_phase = P_FLASH;
            m_rem   = 0;
            m_pend  = 1'b0;
        end else begin
            case (m_phase)
                P_RED: begin
                    if (pr) m_pend = 1'b1;
                    if (m_rem == 1) begin
                        m_phase = P_YELLOW;
                        m_rem   = YELLOW_T;
                    end else begin
                        m_rem = m_rem - 1;
                    end
                end
                P_YELLOW: begin
                    if (pr) m_pend = 1'b1;
                    if (m_rem == 1) begin
                        m_phase = P_GREEN;
                        if (m_pend) begin
                            m_rem  = PASS_T;
                            m_ack  = 1'b1;
                            m_pend = 1'b0;
                        end else begin
                            m_rem = GREEN_T;
                        end
                    end else begin
                        m_rem = m_rem - 1;
                    end
                end
                P_GREEN: begin
                    if (m_rem == 1) begin
                        m_phase = P_RED;
                        m_rem   = RED_T;
                    end else if (pr && m_rem > PASS_T) begin
                        m_rem = PASS_T;
                        m_ack = 1'b1;
                    end else begin
                        m_rem = m_rem - 1;
                    end
                end
                default: begin
                    m_phase = P_RED;
                    m_rem   = RED_T;
                end
            endcase
        end
    endtask

    function automatic logic [CNT_W+3:0] exp_vec();
        logic y;
        y = (m_phase == P_YELLOW) ||
            (m_phase == P_FLASH && ((m_ft / FLASH_HALF) % 2 == 0));
        return {CNT_W'(m_rem), m_phase == P_RED, y, m_phase == P_GREEN, m_ack};
    endfunction

    task automatic cycle(input logic pr, input logic fm, input logic r);
        pass_request = pr;
        flash_mode   = fm;
        rst          = r;
        @(posedge clk);
        model_step(pr, fm, r);
        #1;
    endtask

    // Idle stepping until the model reaches the given phase/remaining time.
    task automatic advance_to(input int ph, input int rem);
        for (int i = 0; i < 300; i++) begin
            if (m_phase == ph && m_rem == rem) break;
            cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (dut_vec !== '0) $display("FAIL reset_outputs: got %h want 0", dut_vec);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (dut_vec !== '0) $display("FAIL reset_idle: got %h want 0", dut_vec);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== {CNT_W'(RED_T), 4'b1000})
            $display("FAIL reset_release_red: got %h want %h", dut_vec, {CNT_W'(RED_T), 4'b1000});
        else n_pass++;
    endtask

    task automatic test_normal_cycle();
        logic [CNT_W+3:0] want;
        int k;
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            k = i % (RED_T + YELLOW_T + GREEN_T);
            if (k < RED_T)                 want = {CNT_W'(RED_T - k), 4'b1000};
            else if (k < RED_T + YELLOW_T) want = {CNT_W'(YELLOW_T - (k - RED_T)), 4'b0100};
            else want = {CNT_W'(GREEN_T - (k - RED_T - YELLOW_T)), 4'b0010};
            n_checks++;
            if (dut_vec !== want) $display("FAIL normal_cycle[%0d]: got %h want %h", i, dut_vec, want);
            else n_pass++;
        end
    endtask

    task automatic test_pass_green();
        advance_to(P_GREEN, 45);
        cycle(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== {CNT_W'(PASS_T), 4'b0011})
            $display("FAIL pass_green_ack: got %h want %h", dut_vec, {CNT_W'(PASS_T), 4'b0011});
        else n_pass++;
        for (int i = 0; i < PASS_T; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL pass_green_run[%0d]: got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (dut_vec !== {CNT_W'(RED_T), 4'b1000})
            $display("FAIL pass_green_end: got %h want %h", dut_vec, {CNT_W'(RED_T), 4'b1000});
        else n_pass++;
    endtask

    task automatic test_pass_late();
        advance_to(P_GREEN, 8);
        cycle(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== {CNT_W'(7), 4'b0010})
            $display("FAIL pass_late_ignored: got %h want %h", dut_vec, {CNT_W'(7), 4'b0010});
        else n_pass++;
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== {CNT_W'(RED_T), 4'b1000})
            $display("FAIL pass_late_expiry: got %h want %h", dut_vec, {CNT_W'(RED_T), 4'b1000});
        else n_pass++;
        // Request on the expiry cycle of green must not ack.
        advance_to(P_GREEN, 1);
        cycle(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== {CNT_W'(RED_T), 4'b1000})
            $display("FAIL pass_on_expiry: got %h want %h", dut_vec, {CNT_W'(RED_T), 4'b1000});
        else n_pass++;
    endtask

    task automatic test_pass_red();
        advance_to(P_RED, 6);
        cycle(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== {CNT_W'(5), 4'b1000})
            $display("FAIL pass_red_hold: got %h want %h", dut_vec, {CNT_W'(5), 4'b1000});
        else n_pass++;
        advance_to(P_GREEN, PASS_T);
        n_checks++;
        if (dut_vec !== {CNT_W'(PASS_T), 4'b0011})
            $display("FAIL pass_red_green_entry: got %h want %h", dut_vec, {CNT_W'(PASS_T), 4'b0011});
        else n_pass++;
        advance_to(P_RED, RED_T);
        advance_to(P_GREEN, GREEN_T);
        n_checks++;
        if (dut_vec !== {CNT_W'(GREEN_T), 4'b0010})
            $display("FAIL pass_red_next_green: got %h want %h", dut_vec, {CNT_W'(GREEN_T), 4'b0010});
        else n_pass++;
    endtask

    task automatic test_flash();
        logic [CNT_W+3:0] want;
        advance_to(P_RED, 6);
        cycle(1'b1, 1'b0, 1'b0);
        advance_to(P_YELLOW, 3);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            want = {CNT_W'(0), 1'b0, ((i / FLASH_HALF) % 2 == 0), 2'b00};
            n_checks++;
            if (dut_vec !== want) $display("FAIL flash[%0d]: got %h want %h", i, dut_vec, want);
            else n_pass++;
        end
        cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== {CNT_W'(RED_T), 4'b1000})
            $display("FAIL flash_exit: got %h want %h", dut_vec, {CNT_W'(RED_T), 4'b1000});
        else n_pass++;
        // Pending was dropped by flash, so the next green is full length.
        for (int i = 0; i < RED_T + YELLOW_T; i++) cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== {CNT_W'(GREEN_T), 4'b0010})
            $display("FAIL flash_pending_cleared: got %h want %h", dut_vec, {CNT_W'(GREEN_T), 4'b0010});
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        advance_to(P_GREEN, 30);
        cycle(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (dut_vec !== '0) $display("FAIL mid_reset_zero: got %h want 0", dut_vec);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec !== {CNT_W'(RED_T), 4'b1000})
            $display("FAIL mid_reset_restart: got %h want %h", dut_vec, {CNT_W'(RED_T), 4'b1000});
        else n_pass++;
    endtask

    task automatic test_random();
        logic fm;
        logic pr;
        logic r;
        fm = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) fm = ~fm;
            pr = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 299) == 0);
            cycle(pr, fm, r);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        pass_request = 1'b0;
        flash_mode   = 1'b0;
        test_reset();
        test_normal_cycle();
        test_pass_green();
        test_pass_late();
        test_pass_red();
        test_flash();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
